// File: rtl/ahb_slave_if_gen_if.sv
// AHB-Lite slave front-end bundle: AHB address/data phase signals in, bridge-side
// pipeline, decode and response signals out.
interface ahb_slave_if_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
);
  // AHB side and APB read-back
  logic              Hwrite;
  logic              Hready_in;
  logic [1:0]        Htrans;
  logic [2:0]        Hsize;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Prdata;

  // Slave outputs
  logic [DATA_W-1:0]  Hrdata;
  logic [ADDR_W-1:0]  Haddr1;
  logic [ADDR_W-1:0]  Haddr2;
  logic [DATA_W-1:0]  Hwdata1;
  logic [DATA_W-1:0]  Hwdata2;
  logic               Hwrite_reg;
  logic               Hwritereg_1;
  logic               valid;
  logic [NUM_SLV-1:0] tempselx;
  logic [1:0]         Hresp;
  logic               Hready_out;
  logic [7:0]         err_count;

  modport slave (
    input  Hwrite, Hready_in, Htrans, Hsize, Haddr, Hwdata, Prdata,
    output Hrdata, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwrite_reg, Hwritereg_1,
           valid, tempselx, Hresp, Hready_out, err_count
  );

  modport master (
    output Hwrite, Hready_in, Htrans, Hsize, Haddr, Hwdata, Prdata,
    input  Hrdata, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwrite_reg, Hwritereg_1,
           valid, tempselx, Hresp, Hready_out, err_count
  );
endinterface

// File: rtl/ahb_slave_if_gen.sv
// AHB-Lite slave front end for the AHB-to-APB bridge. Decodes NUM_SLV equal
// address regions into a one-hot select, pipelines address/data/direction two
// stages deep (held during wait states) and answers illegal transfers with the
// two-cycle AHB ERROR response while counting them in a saturating counter.
module ahb_slave_if_gen #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int                RGN_SHIFT = 26
) (
  input logic                 Hclk,
  input logic                 Hreset,
  ahb_slave_if_gen_if.slave   bus
);

  // Largest legal Hsize: a transfer may not be wider than the data bus.
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  // Window bounds carry one extra bit so a window ending at the top of the
  // address space does not wrap back to zero.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + ((ADDR_W + 1)'(NUM_SLV) << RGN_SHIFT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W:0]   addr_ext;
  logic              in_window;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] region_idx;
  logic [ADDR_W-1:0] align_mask;
  logic              size_bad;
  logic              misaligned;
  logic              active;
  logic              illegal;

  // Read data is passed straight through from the APB side.
  assign bus.Hrdata = bus.Prdata;

  // Address window check, region index and transfer legality.
  always_comb begin
    addr_ext   = {1'b0, bus.Haddr};
    in_window  = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    offset     = bus.Haddr - BASE_ADDR;
    region_idx = offset >> RGN_SHIFT;
    size_bad   = bus.Hsize > 3'(MAX_SIZE);
    align_mask = (ADDR_W'(1) << bus.Hsize) - ADDR_W'(1);
    misaligned = |(bus.Haddr & align_mask);
    // BUSY and IDLE never count as active, so they can never raise an error.
    active     = bus.Hready_in & bus.Htrans[1];
    illegal    = active & (~in_window | size_bad | misaligned);
  end

  // One-hot region select, driven purely from the address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    bus.tempselx = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      bus.tempselx[i] = in_window && (region_idx == ADDR_W'(i));
    end
  end

  // A transfer is handed to the bridge only while no ERROR response is in progress.
  assign bus.valid = active & in_window & ~illegal & (state == ST_IDLE);

  // Response FSM state register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Hreset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Response FSM next state and response decode of the registered state.
  always_comb begin
    state_next     = state;
    bus.Hresp      = 2'b00;
    bus.Hready_out = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (illegal) state_next = ST_ERR1;
      end
      ST_ERR1: begin
        bus.Hresp      = 2'b01;
        bus.Hready_out = 1'b0;
        state_next     = ST_ERR2;
      end
      ST_ERR2: begin
        bus.Hresp  = 2'b01;
        state_next = illegal ? ST_ERR1 : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Saturating count of ERROR responses, advanced once per ERR1 cycle.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      bus.err_count <= 8'd0;
    end else if ((state == ST_ERR1) && (bus.err_count != 8'hFF)) begin
      bus.err_count <= bus.err_count + 8'd1;
    end
  end

  // Two-stage address/data/direction pipeline; every stage holds while the bus waits.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      bus.Haddr1      <= '0;
      bus.Haddr2      <= '0;
      bus.Hwdata1     <= '0;
      bus.Hwdata2     <= '0;
      bus.Hwrite_reg  <= 1'b0;
      bus.Hwritereg_1 <= 1'b0;
    end else if (bus.Hready_in) begin
      bus.Haddr1      <= bus.Haddr;
      bus.Haddr2      <= bus.Haddr1;
      bus.Hwdata1     <= bus.Hwdata;
      bus.Hwdata2     <= bus.Hwdata1;
      bus.Hwrite_reg  <= bus.Hwrite;
      bus.Hwritereg_1 <= bus.Hwrite_reg;
    end
  end

endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// Self-checking bench for ahb_slave_if_gen: decode vector table, hand-written
// error/reset/pipeline sequences and randomized traffic against a reference model.
module tb_ahb_slave_if_gen;

  localparam int          ADDR_W    = 32;
  localparam int          DATA_W    = 32;
  localparam int          NUM_SLV   = 3;
  localparam int          RGN_SHIFT = 26;
  localparam logic [31:0] BASE      = 32'h8000_0000;

  logic Hclk   = 1'b0;
  logic Hreset = 1'b1;
  always #5 Hclk = ~Hclk;

  ahb_slave_if_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

  ahb_slave_if_gen #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(BASE),
    .RGN_SHIFT(RGN_SHIFT)
  ) dut (
    .Hclk  (Hclk),
    .Hreset(Hreset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Region map as plain arithmetic on 64-bit numbers.
  function automatic bit m_in_win(input logic [31:0] a);
    longint unsigned x, lo, hi;
    x  = 64'(a);
    lo = 64'(BASE);
    hi = lo + 64'(NUM_SLV) * (64'd1 << RGN_SHIFT);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [63:0] m_sel(input logic [31:0] a);
    longint unsigned idx;
    if (!m_in_win(a)) return 64'd0;
    idx = (64'(a) - 64'(BASE)) / (64'd1 << RGN_SHIFT);
    return 64'd1 << idx;
  endfunction

  function automatic bit m_active(input logic rdy, input logic [1:0] trans);
    return rdy && (trans == 2'b10 || trans == 2'b11);
  endfunction

  // A 32-bit bus allows byte, halfword and word transfers only.
  function automatic bit m_illegal(input logic [31:0] a, input logic [2:0] size,
                                   input logic [1:0] trans, input logic rdy);
    longint unsigned bytes;
    bytes = 64'd1 << size;
    return m_active(rdy, trans) &&
           (!m_in_win(a) || size > 3'd2 || (64'(a) % bytes) != 0);
  endfunction

  // err_phase: 0 = OKAY, 1 = first ERROR cycle, 2 = second ERROR cycle.
  int          err_phase;
  int          err_total;
  logic [31:0] addr_hist[2];
  logic [31:0] data_hist[2];
  logic        wr_hist[2];

  task automatic model_reset();
    err_phase = 0;
    err_total = 0;
    for (int i = 0; i < 2; i++) begin
      addr_hist[i] = '0;
      data_hist[i] = '0;
      wr_hist[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit ill;
    ill = m_illegal(bus.Haddr, bus.Hsize, bus.Htrans, bus.Hready_in);
    if (err_phase == 1) begin
      err_phase = 2;
      if (err_total < 255) err_total++;
    end else begin
      err_phase = ill ? 1 : 0;
    end
    if (bus.Hready_in) begin
      addr_hist[1] = addr_hist[0]; addr_hist[0] = bus.Haddr;
      data_hist[1] = data_hist[0]; data_hist[0] = bus.Hwdata;
      wr_hist[1]   = wr_hist[0];   wr_hist[0]   = bus.Hwrite;
    end
  endtask

  task automatic check_regs();
    check("Hresp",       64'(bus.Hresp),       (err_phase != 0) ? 64'd1 : 64'd0);
    check("Hready_out",  64'(bus.Hready_out),  (err_phase != 1) ? 64'd1 : 64'd0);
    check("err_count",   64'(bus.err_count),   64'(err_total));
    check("Haddr1",      64'(bus.Haddr1),      64'(addr_hist[0]));
    check("Haddr2",      64'(bus.Haddr2),      64'(addr_hist[1]));
    check("Hwdata1",     64'(bus.Hwdata1),     64'(data_hist[0]));
    check("Hwdata2",     64'(bus.Hwdata2),     64'(data_hist[1]));
    check("Hwrite_reg",  64'(bus.Hwrite_reg),  64'(wr_hist[0]));
    check("Hwritereg_1", 64'(bus.Hwritereg_1), 64'(wr_hist[1]));
  endtask

  // One bus cycle: check combinational outputs for the applied inputs, take the
  // clock edge, then check registered outputs against the model.
  task automatic cycle();
    bit exp_valid;
    #1;
    exp_valid = m_active(bus.Hready_in, bus.Htrans) && m_in_win(bus.Haddr) &&
                !m_illegal(bus.Haddr, bus.Hsize, bus.Htrans, bus.Hready_in) && (err_phase == 0);
    check("valid",    64'(bus.valid),    64'(exp_valid));
    check("tempselx", 64'(bus.tempselx), m_sel(bus.Haddr));
    check("Hrdata",   64'(bus.Hrdata),   64'(bus.Prdata));
    @(posedge Hclk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] size, input logic [1:0] trans,
                       input logic rdy, input logic wr, input logic [31:0] wd);
    bus.Haddr     = a;
    bus.Hsize     = size;
    bus.Htrans    = trans;
    bus.Hready_in = rdy;
    bus.Hwrite    = wr;
    bus.Hwdata    = wd;
    bus.Prdata    = ~wd;
  endtask

  task automatic idle_bus();
    drive(32'h0, 3'd0, 2'b00, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle_bus();
    Hreset = 1'b1;
    @(posedge Hclk);
    #1;
    model_reset();
    check_regs();
    @(negedge Hclk);
    Hreset = 1'b0;
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic        rdy;
    logic        exp_valid;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h8400_0004, 3'd2, 2'b10, 1'b1, 1'b1, 3'b010};
    vecs[1]  = '{32'h8BFF_FFFC, 3'd2, 2'b10, 1'b1, 1'b1, 3'b100};
    vecs[2]  = '{32'h8C00_0000, 3'd2, 2'b10, 1'b1, 1'b0, 3'b000};
    vecs[3]  = '{32'h8000_0000, 3'd2, 2'b10, 1'b1, 1'b1, 3'b001};
    vecs[4]  = '{32'h7FFF_FFF0, 3'd2, 2'b10, 1'b1, 1'b0, 3'b000};
    vecs[5]  = '{32'h8000_0002, 3'd2, 2'b10, 1'b1, 1'b0, 3'b001};
    vecs[6]  = '{32'h8000_0002, 3'd1, 2'b10, 1'b1, 1'b1, 3'b001};
    vecs[7]  = '{32'h8000_0003, 3'd0, 2'b10, 1'b1, 1'b1, 3'b001};
    vecs[8]  = '{32'h8000_0000, 3'd3, 2'b10, 1'b1, 1'b0, 3'b001};
    vecs[9]  = '{32'h8400_0004, 3'd2, 2'b01, 1'b1, 1'b0, 3'b010};
    vecs[10] = '{32'h8400_0004, 3'd2, 2'b11, 1'b1, 1'b1, 3'b010};
    vecs[11] = '{32'h8400_0004, 3'd2, 2'b10, 1'b0, 1'b0, 3'b010};
    vecs[12] = '{32'hFFFF_FFFC, 3'd2, 2'b10, 1'b1, 1'b0, 3'b000};
    vecs[13] = '{32'h87FF_FFFF, 3'd0, 2'b10, 1'b1, 1'b1, 3'b010};

    // Reset state
    do_reset();
    check("reset Hresp", 64'(bus.Hresp), 64'd0);
    check("reset Hready_out", 64'(bus.Hready_out), 64'd1);

    // Decode table: each vector from IDLE, then two idle cycles to drain any ERROR
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].addr, vecs[i].size, vecs[i].trans, vecs[i].rdy, 1'b1, vecs[i].addr ^ 32'h5A5A_0000);
      #1;
      check($sformatf("vec%0d valid", i), 64'(bus.valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d tempselx", i), 64'(bus.tempselx), 64'(vecs[i].exp_sel));
      cycle();
      idle_bus();
      cycle();
      cycle();
    end

    // Reset asserted in ERR1 clears everything immediately
    do_reset();
    drive(32'h7FFF_FFF0, 3'd2, 2'b10, 1'b1, 1'b1, 32'hDEAD_BEEF);
    cycle();
    check("pre-reset Hready_out", 64'(bus.Hready_out), 64'd0);
    idle_bus();
    Hreset = 1'b1;
    #1;
    check("midreset Hresp", 64'(bus.Hresp), 64'd0);
    check("midreset Hready_out", 64'(bus.Hready_out), 64'd1);
    check("midreset err_count", 64'(bus.err_count), 64'd0);
    check("midreset Haddr1", 64'(bus.Haddr1), 64'd0);
    check("midreset Haddr2", 64'(bus.Haddr2), 64'd0);
    check("midreset Hwdata1", 64'(bus.Hwdata1), 64'd0);
    check("midreset Hwrite_reg", 64'(bus.Hwrite_reg), 64'd0);
    model_reset();
    @(negedge Hclk);
    Hreset = 1'b0;
    cycle();

    // Pipeline hold during a wait state
    do_reset();
    drive(32'h8000_0010, 3'd2, 2'b10, 1'b1, 1'b1, 32'h1111_1111); cycle();
    drive(32'h8000_0020, 3'd2, 2'b10, 1'b1, 1'b1, 32'h2222_2222); cycle();
    drive(32'h8000_0030, 3'd2, 2'b10, 1'b0, 1'b0, 32'h3333_3333); cycle();
    check("hold Haddr1", 64'(bus.Haddr1), 64'h8000_0020);
    check("hold Haddr2", 64'(bus.Haddr2), 64'h8000_0010);
    check("hold Hwdata1", 64'(bus.Hwdata1), 64'h2222_2222);
    drive(32'h8000_0030, 3'd2, 2'b10, 1'b1, 1'b0, 32'h3333_3333); cycle();
    check("resume Haddr1", 64'(bus.Haddr1), 64'h8000_0030);
    check("resume Haddr2", 64'(bus.Haddr2), 64'h8000_0020);
    check("resume Hwrite_reg", 64'(bus.Hwrite_reg), 64'd0);
    check("resume Hwritereg_1", 64'(bus.Hwritereg_1), 64'd1);

    // Two-cycle ERROR response for an out-of-window address
    do_reset();
    drive(32'h7FFF_FFF0, 3'd2, 2'b10, 1'b1, 1'b0, 32'h0);
    #1;
    check("err valid", 64'(bus.valid), 64'd0);
    cycle();
    check("err c1 Hresp", 64'(bus.Hresp), 64'd1);
    check("err c1 Hready_out", 64'(bus.Hready_out), 64'd0);
    idle_bus();
    cycle();
    check("err c2 Hresp", 64'(bus.Hresp), 64'd1);
    check("err c2 Hready_out", 64'(bus.Hready_out), 64'd1);
    check("err c2 err_count", 64'(bus.err_count), 64'd1);
    cycle();
    check("err c3 Hresp", 64'(bus.Hresp), 64'd0);
    check("err c3 Hready_out", 64'(bus.Hready_out), 64'd1);
    check("err c3 err_count", 64'(bus.err_count), 64'd1);

    // Misaligned word errors, same address as halfword is fine
    drive(32'h8000_0002, 3'd2, 2'b10, 1'b1, 1'b0, 32'h0);
    cycle();
    check("misalign Hresp", 64'(bus.Hresp), 64'd1);
    idle_bus(); cycle(); cycle();
    drive(32'h8000_0002, 3'd1, 2'b10, 1'b1, 1'b0, 32'h0);
    #1;
    check("aligned hw valid", 64'(bus.valid), 64'd1);
    cycle();
    check("aligned hw Hresp", 64'(bus.Hresp), 64'd0);
    check("misalign err_count", 64'(bus.err_count), 64'd2);

    // Back-to-back: illegal during ERR2 re-enters ERR1
    do_reset();
    drive(32'h9000_0000, 3'd2, 2'b10, 1'b1, 1'b0, 32'h0);
    cycle(); cycle(); cycle();
    check("b2b Hresp", 64'(bus.Hresp), 64'd1);
    check("b2b Hready_out", 64'(bus.Hready_out), 64'd0);
    check("b2b err_count", 64'(bus.err_count), 64'd1);
    cycle();
    check("b2b err_count 2", 64'(bus.err_count), 64'd2);
    idle_bus(); cycle(); cycle();
    // BUSY with a bad address never errors
    drive(32'h7000_0001, 3'd3, 2'b01, 1'b1, 1'b0, 32'h0);
    cycle();
    check("busy Hresp", 64'(bus.Hresp), 64'd0);
    check("busy Hready_out", 64'(bus.Hready_out), 64'd1);

    // Saturation: 300 consecutive errors
    do_reset();
    drive(32'h7FFF_FFF0, 3'd2, 2'b10, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 600; i++) cycle();
    check("saturated err_count", 64'(bus.err_count), 64'd255);
    idle_bus(); cycle(); cycle();
    check("saturated held", 64'(bus.err_count), 64'd255);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      logic [31:0] edges[6];
      edges[0] = 32'h7FFF_FFFC; edges[1] = 32'h8000_0000; edges[2] = 32'h83FF_FFFC;
      edges[3] = 32'h8400_0000; edges[4] = 32'h8BFF_FFFC; edges[5] = 32'h8C00_0000;
      case ($urandom_range(0, 3))
        0:       a = BASE + 32'($urandom_range(0, 32'h0BFF_FFFF));
        1:       a = edges[$urandom_range(0, 5)];
        2:       a = $urandom();
        default: a = BASE + (32'($urandom_range(0, 3)) << RGN_SHIFT) + 32'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      drive(a, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), $urandom());
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
